// File: rtl/fetch_irq_unit_pkg.sv
// Shared definitions for the fetch / interrupt-injection unit: sequencer
// state encoding, the load-immediate encoding used for injected
// instructions, and the pipeline bubble word.
package fetch_irq_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_SAVE_EPC  = 2'd1,
    ST_LOAD_DATA = 2'd2,
    ST_VECTOR    = 2'd3
  } fetch_state_e;

  localparam logic [5:0]  LI_OPCODE = 6'b001001;
  localparam logic [4:0]  REG_EPC   = 5'd30;
  localparam logic [4:0]  REG_IDR   = 5'd28;
  localparam logic [31:0] BUBBLE    = 32'hFFFF_FFFF;

  // Build "LI rt, imm": the target register sits in the first register
  // field and the second register field is zero.
  function automatic logic [31:0] li_instr(input logic [4:0] rt, input logic [15:0] imm);
    return {LI_OPCODE, rt, 5'b00000, imm};
  endfunction

endpackage

// File: rtl/fetch_irq_unit_irq_arbiter.sv
// Interrupt request latches with a fixed-priority selector. Channel 0 wins.
// A request pulse in the same cycle as arbitration takes part directly, so a
// channel can be accepted in the very cycle its pulse arrives.
module irq_arbiter
  import fetch_irq_unit_pkg::*;
#(
  parameter int NUM_IRQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               accept,
  output logic               any_req,
  output logic [NUM_IRQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  logic [NUM_IRQ-1:0] pending_r;
  logic [NUM_IRQ-1:0] req_s;
  logic [NUM_IRQ-1:0] grant_s;
  logic [IDX_W-1:0]   idx_s;

  assign req_s     = pending_r | irq_req;
  assign any_req   = |req_s;
  assign grant     = grant_s;
  assign grant_idx = idx_s;

  // Fixed-priority pick: scan downwards so the lowest set index is kept.
  always_comb begin
    grant_s = {NUM_IRQ{1'b0}};
    idx_s   = {IDX_W{1'b0}};
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_s[i]) begin
        grant_s    = {NUM_IRQ{1'b0}};
        grant_s[i] = 1'b1;
        idx_s      = IDX_W'(i);
      end else begin
        grant_s = grant_s;
      end
    end
  end

  // Pending latches; the accepted channel is cleared, which also swallows a
  // coincident pulse on that same channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= {NUM_IRQ{1'b0}};
    end else if (accept) begin
      pending_r <= req_s & ~grant_s;
    end else begin
      pending_r <= req_s;
    end
  end

endmodule

// File: rtl/fetch_irq_unit.sv
// Instruction fetch stage with interrupt entry. On acceptance it injects
// "LI r30, epc" and optionally "LI r28, data" into the IF/ID register, then
// fetches from the channel's vector. instr_out/keep_flags form the IF/ID
// register and are loaded with whatever the current state produces.
module fetch_irq_unit
  import fetch_irq_unit_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter int                 NUM_IRQ  = 3,
  parameter logic [ADDR_W-1:0]  VEC_BASE = 32'h0000_03FC,
  parameter logic [NUM_IRQ-1:0] HAS_DATA = 3'b001
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [ADDR_W-1:0]    redirect_pc,
  input  logic                 irq_enable,
  input  logic [NUM_IRQ-1:0]   irq_req,
  input  logic [8*NUM_IRQ-1:0] irq_data,
  input  logic [31:0]          instr_in,
  output logic [ADDR_W-1:0]    pc_im,
  output logic                 instr_en,
  output logic [31:0]          instr_out,
  output logic [ADDR_W-1:0]    pc_curr,
  output logic [ADDR_W-1:0]    pc_plus_1,
  output logic                 keep_flags,
  output logic [NUM_IRQ-1:0]   irq_ack,
  output logic [ADDR_W-1:0]    epc,
  output logic                 busy
);

  localparam int                IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1'b1);

  fetch_state_e       state_r, state_nxt_s;
  logic [ADDR_W-1:0]  pc_r, pc_nxt_s;
  logic [ADDR_W-1:0]  epc_r, epc_nxt_s;
  logic [31:0]        instr_r, instr_nxt_s;
  logic               keep_r, keep_nxt_s;
  logic [NUM_IRQ-1:0] ack_r, ack_nxt_s;
  logic               busy_r;
  logic [IDX_W-1:0]   ch_r, ch_nxt_s;
  logic [7:0]         data_r, data_nxt_s;
  logic [ADDR_W-1:0]  seq_pc_s, vector_s, pc_im_s;
  logic               instr_en_s, accept_s, any_req_s;
  logic [NUM_IRQ-1:0] grant_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic [7:0]         data_sel_s;

  irq_arbiter #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IDX_W)
  ) u_irq_arbiter (
    .clk       (clk),
    .rst       (rst),
    .irq_req   (irq_req),
    .accept    (accept_s),
    .any_req   (any_req_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  assign seq_pc_s   = redirect_valid ? redirect_pc : (pc_r + ONE);
  assign vector_s   = VEC_BASE + ONE + ADDR_W'(ch_r);
  assign accept_s   = (state_r == ST_RUN) && irq_enable && !stall && any_req_s;
  assign data_sel_s = irq_data[{grant_idx_s, 3'b000} +: 8];

  assign pc_im      = pc_im_s;
  assign instr_en   = instr_en_s;
  assign instr_out  = instr_r;
  assign pc_curr    = pc_r;
  assign pc_plus_1  = pc_r + ONE;
  assign keep_flags = keep_r;
  assign irq_ack    = ack_r;
  assign epc        = epc_r;
  assign busy       = busy_r;

  // Sequencer next-state, fetch address and IF/ID contents.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    epc_nxt_s   = epc_r;
    instr_nxt_s = instr_r;
    keep_nxt_s  = keep_r;
    ack_nxt_s   = {NUM_IRQ{1'b0}};
    ch_nxt_s    = ch_r;
    data_nxt_s  = data_r;
    pc_im_s     = pc_r;
    instr_en_s  = 1'b0;
    case (state_r)
      ST_RUN: begin
        instr_en_s = !stall;
        if (!stall) begin
          pc_nxt_s    = seq_pc_s;
          instr_nxt_s = redirect_valid ? BUBBLE : instr_in;
          keep_nxt_s  = 1'b0;
        end else begin
          pc_nxt_s = pc_r;
        end
        if (accept_s) begin
          ack_nxt_s   = grant_s;
          epc_nxt_s   = seq_pc_s;
          ch_nxt_s    = grant_idx_s;
          data_nxt_s  = data_sel_s;
          state_nxt_s = ST_SAVE_EPC;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_SAVE_EPC: begin
        if (!stall) begin
          instr_nxt_s = li_instr(REG_EPC, epc_r[15:0]);
          keep_nxt_s  = 1'b1;
          state_nxt_s = HAS_DATA[ch_r] ? ST_LOAD_DATA : ST_VECTOR;
        end else begin
          state_nxt_s = ST_SAVE_EPC;
        end
      end
      ST_LOAD_DATA: begin
        if (!stall) begin
          instr_nxt_s = li_instr(REG_IDR, {8'h00, data_r});
          keep_nxt_s  = 1'b1;
          state_nxt_s = ST_VECTOR;
        end else begin
          state_nxt_s = ST_LOAD_DATA;
        end
      end
      ST_VECTOR: begin
        pc_im_s    = vector_s;
        instr_en_s = !stall;
        if (!stall) begin
          instr_nxt_s = instr_in;
          keep_nxt_s  = 1'b0;
          pc_nxt_s    = vector_s + ONE;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_VECTOR;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
        instr_nxt_s = BUBBLE;
        keep_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, PC, EPC, captured channel/data and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
      pc_r    <= {ADDR_W{1'b0}};
      epc_r   <= {ADDR_W{1'b0}};
      instr_r <= BUBBLE;
      keep_r  <= 1'b0;
      ack_r   <= {NUM_IRQ{1'b0}};
      busy_r  <= 1'b0;
      ch_r    <= {IDX_W{1'b0}};
      data_r  <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      epc_r   <= epc_nxt_s;
      instr_r <= instr_nxt_s;
      keep_r  <= keep_nxt_s;
      ack_r   <= ack_nxt_s;
      busy_r  <= (state_nxt_s != ST_RUN);
      ch_r    <= ch_nxt_s;
      data_r  <= data_nxt_s;
    end
  end

endmodule

// File: tb/tb_fetch_irq_unit.sv
// Directed bench for fetch_irq_unit. Instruction memory is modelled as
// {8'hC0, pc_im[23:0]}, so a fetched word is easy to predict by hand.
module tb_fetch_irq_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        irq_enable;
  logic [2:0]  irq_req;
  logic [23:0] irq_data;
  logic [31:0] instr_in;
  logic [31:0] pc_im;
  logic        instr_en;
  logic [31:0] instr_out;
  logic [31:0] pc_curr;
  logic [31:0] pc_plus_1;
  logic        keep_flags;
  logic [2:0]  irq_ack;
  logic [31:0] epc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fetch_irq_unit #(
    .ADDR_W   (32),
    .NUM_IRQ  (3),
    .VEC_BASE (32'h0000_03FC),
    .HAS_DATA (3'b001)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .irq_enable     (irq_enable),
    .irq_req        (irq_req),
    .irq_data       (irq_data),
    .instr_in       (instr_in),
    .pc_im          (pc_im),
    .instr_en       (instr_en),
    .instr_out      (instr_out),
    .pc_curr        (pc_curr),
    .pc_plus_1      (pc_plus_1),
    .keep_flags     (keep_flags),
    .irq_ack        (irq_ack),
    .epc            (epc),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model.
  always_comb instr_in = {8'hC0, pc_im[23:0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Redirects must only ever be driven while the sequencer is in RUN.
  always @(negedge clk) begin
    if (!rst && redirect_valid) begin
      checks++;
      assert (busy === 1'b0) else begin
        errors++;
        $error("FAIL redirect_in_run: busy %b expected 0", busy);
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    irq_enable = 1'b1; irq_req = 3'b000; irq_data = {8'h66, 8'h55, 8'h41};

    // Reset values
    nxt(); nxt(); mid();
    chk("rst_pc_curr", pc_curr, 32'h0);
    chk("rst_pc_plus_1", pc_plus_1, 32'h1);
    chk("rst_epc", epc, 32'h0);
    chk("rst_instr_out", instr_out, 32'hFFFF_FFFF);
    chk("rst_ack", {29'h0, irq_ack}, 32'h0);
    chk("rst_keep", {31'h0, keep_flags}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);

    // Free run
    nxt(); rst = 1'b0; mid();
    chk("run0_pc_im", pc_im, 32'h0);
    chk("run0_plus1", pc_plus_1, 32'h1);
    chk("run0_instr_en", {31'h0, instr_en}, 32'h1);
    chk("run0_instr_out", instr_out, 32'hFFFF_FFFF);
    nxt(); mid();
    chk("run1_pc_im", pc_im, 32'h1);
    chk("run1_plus1", pc_plus_1, 32'h2);
    chk("run1_instr_out", instr_out, 32'hC000_0000);
    nxt(); mid();
    chk("run2_pc_im", pc_im, 32'h2);
    chk("run2_plus1", pc_plus_1, 32'h3);
    nxt(); redirect_valid = 1'b1; redirect_pc = 32'h10; mid();
    chk("run3_pc_im", pc_im, 32'h3);
    chk("run3_plus1", pc_plus_1, 32'h4);

    // Channel 0 with data at pc 0x10
    nxt(); redirect_valid = 1'b0; irq_req = 3'b001; mid();
    chk("redir_pc_im", pc_im, 32'h10);
    chk("redir_bubble", instr_out, 32'hFFFF_FFFF);
    nxt(); irq_req = 3'b000; mid();
    chk("c0_ack", {29'h0, irq_ack}, 32'h1);
    chk("c0_busy", {31'h0, busy}, 32'h1);
    chk("c0_epc", epc, 32'h11);
    chk("c0_instr_en", {31'h0, instr_en}, 32'h0);
    chk("c0_last_fetch", instr_out, 32'hC000_0010);
    nxt(); mid();
    chk("c0_li_epc", instr_out, 32'h27C0_0011);
    chk("c0_keep", {31'h0, keep_flags}, 32'h1);
    chk("c0_ack_once", {29'h0, irq_ack}, 32'h0);
    nxt(); mid();
    chk("c0_li_data", instr_out, 32'h2780_0041);
    chk("c0_vec_pc_im", pc_im, 32'h3FD);
    chk("c0_vec_en", {31'h0, instr_en}, 32'h1);

    // Channels 2 and 1 together
    nxt(); irq_req = 3'b110; mid();
    chk("c0_ret_pc", pc_curr, 32'h3FE);
    chk("c0_ret_busy", {31'h0, busy}, 32'h0);
    chk("c0_ret_instr", instr_out, 32'hC000_03FD);
    chk("c0_ret_keep", {31'h0, keep_flags}, 32'h0);
    nxt(); irq_req = 3'b000; mid();
    chk("c1_ack", {29'h0, irq_ack}, 32'h2);
    chk("c1_epc", epc, 32'h3FF);
    nxt(); mid();
    chk("c1_vec_pc_im", pc_im, 32'h3FE);
    chk("c1_li_epc", instr_out, 32'h27C0_03FF);
    nxt(); mid();
    chk("c1_ret_pc", pc_im, 32'h3FF);
    chk("c1_ret_busy", {31'h0, busy}, 32'h0);
    chk("c1_ret_instr", instr_out, 32'hC000_03FE);
    nxt(); mid();
    chk("c2_ack", {29'h0, irq_ack}, 32'h4);
    chk("c2_epc", epc, 32'h400);
    chk("c2_busy", {31'h0, busy}, 32'h1);
    nxt(); mid();
    chk("c2_vec_pc_im", pc_im, 32'h3FF);
    chk("c2_li_epc", instr_out, 32'h27C0_0400);

    // Redirect at acceptance, then stall in SAVE_EPC
    nxt(); irq_req = 3'b001; irq_data = {8'h66, 8'h55, 8'h07};
    redirect_valid = 1'b1; redirect_pc = 32'h80; mid();
    chk("rd_pc_im", pc_im, 32'h400);
    nxt(); irq_req = 3'b000; redirect_valid = 1'b0; stall = 1'b1; mid();
    chk("rd_epc", epc, 32'h80);
    chk("rd_ack", {29'h0, irq_ack}, 32'h1);
    chk("rd_bubble", instr_out, 32'hFFFF_FFFF);
    for (int k = 0; k < 2; k++) begin
      nxt(); mid();
      chk("stall_instr", instr_out, 32'hFFFF_FFFF);
      chk("stall_en", {31'h0, instr_en}, 32'h0);
      chk("stall_busy", {31'h0, busy}, 32'h1);
      chk("stall_keep", {31'h0, keep_flags}, 32'h0);
    end
    nxt(); stall = 1'b0; mid();
    chk("unstall_instr", instr_out, 32'hFFFF_FFFF);
    nxt(); mid();
    chk("rd_li_epc", instr_out, 32'h27C0_0080);
    nxt(); mid();
    chk("rd_li_data", instr_out, 32'h2780_0007);
    chk("rd_vec_pc_im", pc_im, 32'h3FD);
    nxt(); mid();
    chk("rd_ret_pc", pc_im, 32'h3FE);

    // Interrupts disabled while channel 1 is pending
    nxt(); irq_enable = 1'b0; irq_req = 3'b010; mid();
    chk("dis_pc_im", pc_im, 32'h3FF);
    for (int k = 0; k < 5; k++) begin
      nxt(); irq_req = 3'b000; mid();
      chk("dis_no_ack", {29'h0, irq_ack}, 32'h0);
      chk("dis_busy", {31'h0, busy}, 32'h0);
      chk("dis_pc_im", pc_im, 32'h400 + 32'(k));
    end
    nxt(); irq_enable = 1'b1; mid();
    chk("en_cycle_ack", {29'h0, irq_ack}, 32'h0);
    nxt(); mid();
    chk("en_ack", {29'h0, irq_ack}, 32'h2);
    chk("en_epc", epc, 32'h406);
    nxt(); mid();
    chk("en_vec_pc_im", pc_im, 32'h3FE);

    // Reset during LOAD_DATA, with channel 2 pending
    nxt(); irq_req = 3'b001; irq_data = {8'h66, 8'h55, 8'h41}; mid();
    chk("r_pc_im", pc_im, 32'h3FF);
    nxt(); irq_req = 3'b100; mid();
    chk("r_ack", {29'h0, irq_ack}, 32'h1);
    nxt(); irq_req = 3'b000; mid();
    chk("r_li_epc", instr_out, 32'h27C0_0400);
    chk("r_busy", {31'h0, busy}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("ra_busy", {31'h0, busy}, 32'h0);
    chk("ra_pc", pc_curr, 32'h0);
    chk("ra_pc_im", pc_im, 32'h0);
    chk("ra_epc", epc, 32'h0);
    chk("ra_instr", instr_out, 32'hFFFF_FFFF);
    chk("ra_keep", {31'h0, keep_flags}, 32'h0);
    nxt(); rst = 1'b0; mid();
    chk("rr_pc_im0", pc_im, 32'h0);
    for (int k = 1; k < 3; k++) begin
      nxt(); mid();
      chk("rr_no_ack", {29'h0, irq_ack}, 32'h0);
      chk("rr_busy", {31'h0, busy}, 32'h0);
      chk("rr_pc_im", pc_im, 32'(k));
    end

    // PC wrap
    nxt(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; mid();
    nxt(); redirect_valid = 1'b0; mid();
    chk("wrap_pc_im", pc_im, 32'hFFFF_FFFF);
    chk("wrap_plus1", pc_plus_1, 32'h0);
    nxt(); mid();
    chk("wrap_next", pc_im, 32'h0);
    chk("wrap_next_plus1", pc_plus_1, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
